sram_arbiter: RTL
=================

# sram_arbiter

Two-port arbiter that shares the single off-chip SRAM controller between two requesters: port 0 (MEM-stage data memory) and port 1 (secondary master, e.g. instruction fetch or debug loader). It grants one transaction at a time and holds the downstream request stable until completion. It returns read data and a one-cycle done pulse to the winning port, and exposes per-port stall signals for pipeline freeze. It sits between the requesters and the SRAM controller's wrEn/rdEn/address/writeData/readData/ready interface.

## Interface
- No parameters. Address and data widths are fixed at 32 bits.
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- pN_wr_en  in  1  port N write request, level, N∈{0,1}
- pN_rd_en  in  1  port N read request, level
- pN_addr  in  32  port N byte address
- pN_wdata  in  32  port N write data
- pN_rdata  out  32  port N read data, valid while pN_ready=1
- pN_ready  out  1  port N completion pulse, one cycle
- pN_stall  out  1  combinational: (pN_wr_en|pN_rd_en) & ~pN_ready
- mem_wr_en  out  1  to SRAM controller wrEn
- mem_rd_en  out  1  to SRAM controller rdEn
- mem_addr  out  32  to controller address
- mem_wdata  out  32  to controller writeData
- mem_rdata  in  32  from controller readData
- mem_ready  in  1  from controller ready
- grant_id  out  1  port currently owning the SRAM; valid in BUSY/RESP

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: a port is requesting if its wr_en or rd_en is set.
  - No requests: stay in IDLE.
  - Otherwise pick a winner, then latch its addr, wdata and op (write if wr_en=1; wr_en wins if both wr_en and rd_en are set) → BUSY.
- BUSY: drive mem_wr_en/mem_rd_en/mem_addr/mem_wdata from the latched registers, held constant.
  - mem_ready=1 in BUSY marks completion. Capture mem_rdata into the grantee's rdata register → RESP.
  - mem_ready is ignored outside BUSY.
- RESP: deassert mem_wr_en/mem_rd_en so the controller returns to its idle state. Assert p[grant_id]_ready for exactly one cycle → IDLE.
- Requester rule: hold the request and operands until pN_ready. Deassert or change them on the next edge. Changes made to operands after grant are ignored.
- The non-granted port keeps its request pending. It is served in the next IDLE cycle; it is never dropped.
- Write transactions also return pN_ready. pN_rdata is unchanged on writes.
- pN_rdata holds its last captured value between transactions.

## Timing
- Reset values: all mem_* outputs 0, pN_ready 0, pN_rdata 0, grant_id 0, state IDLE, last_grant 1.
- Latency: request seen in IDLE at cycle t.
  - mem request asserted at t+1.
  - Controller completion (mem_ready) at t+1+L.
  - pN_ready at t+2+L.
  - Arbiter overhead is 2 cycles over the controller latency L.
- Back-to-back: the earliest next grant is in the IDLE cycle following RESP. There is one dead cycle per transaction.
- Simultaneous requests from both ports in IDLE are resolved per Configuration.
- rst mid-transaction: the FSM returns to IDLE next cycle, mem_* requests drop, and no pN_ready is issued. The controller shares the same rst.
- mem_ready=1 in the first BUSY cycle is treated as completion. It cannot occur with a compliant controller.

## Configuration
- SRAM_ARB_RR_EN defined: round-robin arbitration.
  - On contention, grant the port ≠ last_grant.
  - last_grant updates at every grant.
  - A single requester is always granted.
- Undefined: fixed priority. Port 0 always wins contention, last_grant is not implemented, and port 1 can starve.

## Structure
- Shared package sram_arb_pkg holds:
  - state encodings IDLE=2'd0, BUSY=2'd1, RESP=2'd2;
  - port ids PORT_MEM=1'b0, PORT_AUX=1'b1;
  - OP_READ/OP_WRITE constants.
- One sub-module, sram_arb_pick: combinational winner selection from (req0, req1, last_grant) → (valid, winner). The round-robin/fixed choice is made there under the macro.

## Test plan
- Single read: p0_rd_en=1, p0_addr=0x400, controller model returns 0xDEADBEEF with L=6 → mem_rd_en high for cycles 1..7, p0_ready pulse at cycle 8 with p0_rdata=0xDEADBEEF, p1_* untouched.
- Write then read: p1 writes 0x12345678 to 0x404, then reads 0x404 → mem_wdata=0x12345678 held through BUSY; read returns 0x12345678; exactly one p1_ready per transaction.
- Contention, RR build: p0 and p1 both request continuously for 4 transactions → grant_id sequence 0,1,0,1. Fixed build → 0,0,0,0 while p0 keeps requesting.
- Both ops on one port: p0_wr_en=p0_rd_en=1 → mem_wr_en=1, mem_rd_en=0; p0_rdata unchanged.
- Reset mid-BUSY: assert rst in the 3rd BUSY cycle → next cycle mem_wr_en=mem_rd_en=0, state IDLE, no pN_ready, pN_rdata=0.
- Stall/handshake: p0 requests while p1 is in BUSY → p0_stall=1 every cycle until p0_ready, and mem_addr stays equal to p1_addr until p1's RESP.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg
//   Shared constants and types for the two-port SRAM arbiter:
//   FSM state encodings, port identifiers, operation codes and the
//   latched downstream request record.
`timescale 1ns/1ps
package sram_arb_pkg;

  // FSM state encodings
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // Port identifiers
  localparam logic PORT_MEM = 1'b0;  // MEM-stage data memory
  localparam logic PORT_AUX = 1'b1;  // secondary master (fetch / debug loader)

  // Operation codes
  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  // Downstream request captured at grant time and held through BUSY
  typedef struct packed {
    logic        op;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/sram_arb_pick.sv
// sram_arb_pick
//   Combinational winner selection between two requesters.
//   Ports:
//     req0, req1  : port 0 / port 1 request (wr_en | rd_en)
//     last_grant  : port granted most recently (round-robin history)
//     valid       : at least one port is requesting
//     winner      : selected port id (PORT_MEM / PORT_AUX)
//   Build option: SRAM_ARB_RR_EN defined -> round-robin on contention;
//   undefined -> fixed priority, port 0 always wins and last_grant is ignored.
`timescale 1ns/1ps
module sram_arb_pick
  import sram_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic valid,
  output logic winner
);

  assign valid = req0 | req1;

`ifdef SRAM_ARB_RR_EN
  // On contention hand the SRAM to the port that did not win last time;
  // a lone requester is always granted.
  always_comb begin
    winner = PORT_MEM;
    if (req0 && req1) begin
      winner = ~last_grant;
    end else if (req1) begin
      winner = PORT_AUX;
    end
  end
`else
  // Fixed priority: history is not used in this build.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    winner = PORT_MEM;
    if (!req0 && req1) begin
      winner = PORT_AUX;
    end
  end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Shares one off-chip SRAM controller between two requesters. One
//   transaction at a time: IDLE (arbitrate, latch operands) -> BUSY (drive
//   the controller until mem_ready) -> RESP (one-cycle pN_ready) -> IDLE.
//   Ports:
//     clk, rst                 : clock, synchronous active-high reset
//     pN_wr_en/pN_rd_en        : port N level requests (wr wins if both set)
//     pN_addr/pN_wdata         : port N operands, sampled at grant
//     pN_rdata                 : port N read data, held between transactions
//     pN_ready                 : port N one-cycle completion pulse
//     pN_stall                 : request pending and not completing this cycle
//     mem_wr_en/mem_rd_en      : controller request, high only in BUSY
//     mem_addr/mem_wdata       : controller operands from the latched request
//     mem_rdata/mem_ready      : controller response
//     grant_id                 : port owning the SRAM (valid in BUSY/RESP)
//   Build option: SRAM_ARB_RR_EN selects round-robin arbitration (default:
//   fixed priority with port 0 first).
`timescale 1ns/1ps
module sram_arbiter
  import sram_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_wr_en,
  input  logic        p0_rd_en,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic [31:0] p0_rdata,
  output logic        p0_ready,
  output logic        p0_stall,
  input  logic        p1_wr_en,
  input  logic        p1_rd_en,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic [31:0] p1_rdata,
  output logic        p1_ready,
  output logic        p1_stall,
  output logic        mem_wr_en,
  output logic        mem_rd_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        grant_id
);

  logic [1:0]  state_reg;
  logic        grant_reg;
  mem_req_t    req_reg;
  logic        last_grant;

  // Per-port views so the per-port logic can be generated once
  logic [1:0]  port_wr;
  logic [1:0]  port_rd;
  logic [31:0] port_addr  [2];
  logic [31:0] port_wdata [2];
  logic [1:0]  ready_vec;
  logic [1:0]  stall_vec;
  logic [63:0] rdata_vec;

  assign port_wr       = {p1_wr_en, p0_wr_en};
  assign port_rd       = {p1_rd_en, p0_rd_en};
  assign port_addr[0]  = p0_addr;
  assign port_addr[1]  = p1_addr;
  assign port_wdata[0] = p0_wdata;
  assign port_wdata[1] = p1_wdata;

  logic pick_valid;
  logic pick_winner;

  sram_arb_pick u_pick (
    .req0       (port_wr[0] | port_rd[0]),
    .req1       (port_wr[1] | port_rd[1]),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  // Completion seen by the arbiter; mem_ready outside BUSY is ignored.
  logic busy_done;
  assign busy_done = (state_reg == BUSY) && mem_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      grant_reg <= PORT_MEM;
      req_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            state_reg     <= BUSY;
            grant_reg     <= pick_winner;
            req_reg.op    <= port_wr[pick_winner] ? OP_WRITE : OP_READ;
            req_reg.addr  <= port_addr[pick_winner];
            req_reg.wdata <= port_wdata[pick_winner];
          end
        end
        BUSY: begin
          if (mem_ready) begin
            state_reg <= RESP;
          end
        end
        RESP:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef SRAM_ARB_RR_EN
  logic last_grant_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_reg <= PORT_AUX;
    end else if ((state_reg == IDLE) && pick_valid) begin
      last_grant_reg <= pick_winner;
    end
  end

  assign last_grant = last_grant_reg;
`else
  // Fixed priority keeps no history; the picker ignores this input.
  assign last_grant = PORT_AUX;
`endif

  // Per-port read-data capture, completion pulse and stall.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic [31:0] rdata_reg;
    logic        mine;

    assign mine = (grant_reg == 1'(gi));

    // Writes leave the port's read data untouched.
    always_ff @(posedge clk) begin
      if (rst) begin
        rdata_reg <= '0;
      end else if (busy_done && mine && (req_reg.op == OP_READ)) begin
        rdata_reg <= mem_rdata;
      end
    end

    assign ready_vec[gi]            = (state_reg == RESP) && mine;
    assign stall_vec[gi]            = (port_wr[gi] | port_rd[gi]) & ~ready_vec[gi];
    assign rdata_vec[gi*32 +: 32]   = rdata_reg;
  end

  assign p0_ready = ready_vec[0];
  assign p1_ready = ready_vec[1];
  assign p0_stall = stall_vec[0];
  assign p1_stall = stall_vec[1];
  assign p0_rdata = rdata_vec[31:0];
  assign p1_rdata = rdata_vec[63:32];

  // Request strobes only in BUSY so the controller sees them drop in RESP.
  assign mem_wr_en = (state_reg == BUSY) && (req_reg.op == OP_WRITE);
  assign mem_rd_en = (state_reg == BUSY) && (req_reg.op == OP_READ);
  assign mem_addr  = req_reg.addr;
  assign mem_wdata = req_reg.wdata;
  assign grant_id  = grant_reg;

endmodule
